// File: rtl/tick_counter_pkg.sv
// Shared constants for the tick_counter family: end-of-range behaviour selection.
package tick_counter_pkg;

  localparam bit SAT_WRAP = 1'b0;
  localparam bit SAT_HOLD = 1'b1;

endpackage

// File: rtl/tick_counter_if.sv
// Control and status bundle of tick_counter. master drives controls, slave is the counter.
// Handshake: there is none; every control is a level sampled at each posedge clk,
// load is a one-cycle strobe, and tick/tc are one-cycle registered pulses.
interface tick_counter_if #(
  parameter int COUNT_WIDTH = 4
);
  logic                   en;
  logic                   up;
  logic [COUNT_WIDTH-1:0] count_limit;
  logic                   load;
  logic [COUNT_WIDTH-1:0] load_val;
  logic [COUNT_WIDTH-1:0] count;
  logic                   tick;
  logic                   tc;

  modport master (
    output en, up, count_limit, load, load_val,
    input  count, tick, tc
  );

  modport slave (
    input  en, up, count_limit, load, load_val,
    output count, tick, tc
  );
endinterface

// File: rtl/tick_counter_tick_gen.sv
// Prescaler producing a one-clk enable strobe every PRESCALE enabled cycles.
// clr restarts the period and drops any strobe about to be issued.
module tick_gen #(
  parameter int PRESCALE       = 1000,
  parameter int PRESCALE_WIDTH = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  import tick_counter_pkg::*;

  localparam logic [PRESCALE_WIDTH-1:0] LAST = PRESCALE_WIDTH'(PRESCALE - 1);

  logic [PRESCALE_WIDTH-1:0] r_pre;
  logic                      r_tick;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else if (en) begin
      if (r_pre == LAST) begin
        r_pre  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_pre  <= r_pre + PRESCALE_WIDTH'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;
endmodule

// File: rtl/tick_counter.sv
// Up/down counter over 0..count_limit stepped by a prescaler strobe, with load,
// enable, wrap-or-saturate at the range ends and a terminal-count pulse.
module tick_counter #(
  parameter int COUNT_WIDTH    = 4,
  parameter int PRESCALE       = 1000,
  parameter int PRESCALE_WIDTH = 10,
  parameter bit SATURATE       = 1'b0
) (
  input logic         clk,
  input logic         rst,
  tick_counter_if.slave bus
);
  import tick_counter_pkg::*;

  logic                   w_tick;
  logic                   w_step;
  logic                   w_term;
  logic [COUNT_WIDTH-1:0] w_next;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   r_tc;

  tick_gen #(
    .PRESCALE       (PRESCALE),
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (bus.load),
    .tick (w_tick)
  );

  assign w_step = w_tick & bus.en & ~bus.load;

  // Up uses >= so a count loaded or left above a lowered limit still terminates.
  assign w_term = bus.up ? (r_count >= bus.count_limit) : (r_count == '0);

  always_comb begin
    w_next = r_count;
    if (w_term) begin
      if (SATURATE == SAT_WRAP) begin
        w_next = bus.up ? '0 : bus.count_limit;
      end
    end else if (bus.up) begin
      w_next = r_count + COUNT_WIDTH'(1);
    end else begin
      w_next = r_count - COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (bus.load) begin
      r_count <= bus.load_val;
      r_tc    <= 1'b0;
    end else if (w_step) begin
      r_count <= w_next;
      r_tc    <= w_term;
    end else begin
      r_tc    <= 1'b0;
    end
  end

  assign bus.count = r_count;
  assign bus.tick  = w_tick;
  assign bus.tc    = r_tc;
endmodule
